uart_top: RTL and testbench

Memory-mapped 8-bit UART peripheral for the TRSQ8 CPU peripheral bus, decoded at 0x88–0x8B beside the SPI (0x80–0x83) and GPIO (0x84–0x87) slaves. It consumes CPU bus writes and reads. It serialises transmit bytes through a 4-deep TX FIFO onto `tx`, and deserialises `rx` into a 4-deep RX FIFO. Baud rate is a run-time 16-bit divisor; status flags include sticky overrun and framing errors.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_top.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_top.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the TRSQ8 UART peripheral: register map, STATUS bit
// positions, FSM state encodings and 8N1 framing constants.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_BUSY   = 6;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Countdown preload so the start-bit check lands floor((div+1)/2) clocks
  // after the falling edge is seen.
  function automatic logic [15:0] midBitCount(input logic [15:0] div);
    logic [15:0] half;
    half = {1'b0, div[15:1]} + {15'd0, div[0]};
    if (half == 16'd0) begin
      return 16'd0;
    end
    return half - 16'd1;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with combinational head output. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign dout_o  = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + (AW+1)'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_top.sv
// Memory-mapped 8N1 UART for the TRSQ8 peripheral bus: register decode,
// TX/RX FIFOs, and the transmit and receive bit-timing state machines.
module uart_top
  import uart_pkg::*;
#(
  parameter int          ADDR_LSB          = 0,
  parameter int          OPT_MEM_ADDR_BITS = 1,
  parameter int          FIFO_AW           = 2,
  parameter logic [15:0] DEFAULT_DIV       = 16'd867
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       tx,
  input  logic       rx
);

  logic [OPT_MEM_ADDR_BITS:0] regSel;
  logic                       unusedAddr;
  logic wrData, wrStatus, wrDivLo, wrDivHi, rdData;

  logic [15:0] div_q;
  logic        overrun_q, overrun_d;
  logic        frameErr_q, frameErr_d;
  logic [7:0]  status;

  logic       txFull, txEmpty, txPop;
  logic [7:0] txFifoDout;
  tx_state_e  txState_q, txState_d;
  logic [15:0] txCnt_q, txCnt_d, txDiv_q, txDiv_d;
  logic [BIT_IDX_W-1:0] txBit_q, txBit_d;
  logic [7:0] txShift_q, txShift_d;
  logic       tx_q, txLine;

  logic       rxFull, rxEmpty, rxPop, rxPush, frameSet, overrunSet;
  logic [7:0] rxFifoDout;
  logic       rxMeta_q, rxSync_q, rxPrev_q, rxFall;
  rx_state_e  rxState_q, rxState_d;
  logic [15:0] rxCnt_q, rxCnt_d, rxDiv_q, rxDiv_d;
  logic [BIT_IDX_W-1:0] rxBit_q, rxBit_d;
  logic [7:0] rxShift_q, rxShift_d;

  assign regSel     = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign unusedAddr = ^addr;
  assign wrData     = wr_en && (regSel == REG_DATA);
  assign wrStatus   = wr_en && (regSel == REG_STATUS);
  assign wrDivLo    = wr_en && (regSel == REG_DIV_LO);
  assign wrDivHi    = wr_en && (regSel == REG_DIV_HI);
  assign rdData     = rd_en && (regSel == REG_DATA);

  assign rxPop      = rdData && !rxEmpty;
  assign overrunSet = rxPush && rxFull && !rxPop;
  // Sticky flags: a new event in the same cycle as a W1C keeps the flag set.
  assign overrun_d  = (overrun_q && !(wrStatus && din[ST_OVERRUN])) || overrunSet;
  assign frameErr_d = (frameErr_q && !(wrStatus && din[ST_FRAME_ERR])) || frameSet;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= DEFAULT_DIV;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      if (wrDivLo) begin
        div_q[7:0] <= din;
      end
      if (wrDivHi) begin
        div_q[15:8] <= din;
      end
      overrun_q  <= overrun_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    status               = 8'h00;
    status[ST_TX_FULL]   = txFull;
    status[ST_TX_EMPTY]  = txEmpty;
    status[ST_RX_VALID]  = !rxEmpty;
    status[ST_RX_FULL]   = rxFull;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frameErr_q;
    status[ST_TX_BUSY]   = (txState_q != TX_IDLE);
  end

  always_comb begin
    dout = 8'h00;
    case (regSel)
      REG_DATA:   dout = rxEmpty ? 8'h00 : rxFifoDout;
      REG_STATUS: dout = status;
      REG_DIV_LO: dout = div_q[7:0];
      REG_DIV_HI: dout = div_q[15:8];
      default:    dout = 8'h00;
    endcase
  end

  uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_txFifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (wrData),
    .pop_i  (txPop),
    .din_i  (din),
    .dout_o (txFifoDout),
    .full_o (txFull),
    .empty_o(txEmpty)
  );

  uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rxFifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (rxPush),
    .pop_i  (rxPop),
    .din_i  (rxShift_q),
    .dout_o (rxFifoDout),
    .full_o (rxFull),
    .empty_o(rxEmpty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= 16'd0;
      txDiv_q   <= 16'd0;
      txBit_q   <= '0;
      txShift_q <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txDiv_q   <= txDiv_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      tx_q      <= txLine;
    end
  end

  // Each state holds for div+1 clocks; the stop bit chains straight into the
  // next start bit when more data is queued.
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txDiv_d   = txDiv_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPop     = 1'b0;
    case (txState_q)
      TX_IDLE: begin
        if (!txEmpty) begin
          txPop     = 1'b1;
          txShift_d = txFifoDout;
          txDiv_d   = div_q;
          txCnt_d   = div_q;
          txState_d = TX_START;
        end
      end
      TX_START: begin
        if (txCnt_q == 16'd0) begin
          txCnt_d   = txDiv_q;
          txBit_d   = '0;
          txState_d = TX_DATA;
        end else begin
          txCnt_d = txCnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (txCnt_q == 16'd0) begin
          txCnt_d   = txDiv_q;
          txShift_d = {1'b0, txShift_q[7:1]};
          if (txBit_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            txState_d = TX_STOP;
          end else begin
            txBit_d = txBit_q + BIT_IDX_W'(1);
          end
        end else begin
          txCnt_d = txCnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (txCnt_q == 16'd0) begin
          if (!txEmpty) begin
            txPop     = 1'b1;
            txShift_d = txFifoDout;
            txDiv_d   = div_q;
            txCnt_d   = div_q;
            txState_d = TX_START;
          end else begin
            txState_d = TX_IDLE;
          end
        end else begin
          txCnt_d = txCnt_q - 16'd1;
        end
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  always_comb begin
    txLine = 1'b1;
    if (txState_q == TX_START) begin
      txLine = 1'b0;
    end else if (txState_q == TX_DATA) begin
      txLine = txShift_q[0];
    end
  end

  assign tx = tx_q;

  // rxPrev_q trails the synchroniser by one clock to expose the falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta_q  <= 1'b1;
      rxSync_q  <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxState_q <= RX_IDLE;
      rxCnt_q   <= 16'd0;
      rxDiv_q   <= 16'd0;
      rxBit_q   <= '0;
      rxShift_q <= 8'h00;
    end else begin
      rxMeta_q  <= rx;
      rxSync_q  <= rxMeta_q;
      rxPrev_q  <= rxSync_q;
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxDiv_q   <= rxDiv_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
    end
  end

  assign rxFall = rxPrev_q && !rxSync_q;

  // A framing error returns to IDLE; re-arming needs a fresh falling edge,
  // so a line stuck low after a bad stop bit is ignored until it goes high.
  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q;
    rxDiv_d   = rxDiv_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxPush    = 1'b0;
    frameSet  = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        if (rxFall) begin
          rxDiv_d   = div_q;
          rxCnt_d   = midBitCount(div_q);
          rxState_d = RX_START;
        end
      end
      RX_START: begin
        if (rxCnt_q == 16'd0) begin
          if (rxSync_q) begin
            rxState_d = RX_IDLE;
          end else begin
            rxCnt_d   = rxDiv_q;
            rxBit_d   = '0;
            rxState_d = RX_DATA;
          end
        end else begin
          rxCnt_d = rxCnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rxCnt_q == 16'd0) begin
          rxCnt_d   = rxDiv_q;
          rxShift_d = {rxSync_q, rxShift_q[7:1]};
          if (rxBit_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            rxState_d = RX_STOP;
          end else begin
            rxBit_d = rxBit_q + BIT_IDX_W'(1);
          end
        end else begin
          rxCnt_d = rxCnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rxCnt_q == 16'd0) begin
          rxState_d = RX_IDLE;
          if (rxSync_q) begin
            rxPush = 1'b1;
          end else begin
            frameSet = 1'b1;
          end
        end else begin
          rxCnt_d = rxCnt_q - 16'd1;
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_top.sv
// Randomised self-checking bench for uart_top: bus tasks, a serial line
// driver, a TX line decoder and a queue-based model of the RX FIFO and flags.
`timescale 1ns/1ps
module tb_uart_top;

  localparam logic [7:0] A_DATA   = 8'h88;
  localparam logic [7:0] A_STATUS = 8'h89;
  localparam logic [7:0] A_DIV_LO = 8'h8A;
  localparam logic [7:0] A_DIV_HI = 8'h8B;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wr_en;
  logic       rd_en;
  logic       tx;
  logic       rx;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCnt   = 0;
  int divVal     = 867;
  bit monEnable  = 1'b0;

  logic [7:0] rxModel[$];
  bit         overrunModel  = 1'b0;
  bit         frameErrModel = 1'b0;
  logic [7:0] txSeen[$];
  int         txStart[$];

  uart_top dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus cycle; read data is captured just before the strobing edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d,
                               input logic we, input logic re,
                               output logic [7:0] rdata);
    addr  = a;
    din   = d;
    wr_en = we;
    rd_en = re;
    #1;
    rdata = dout;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    applyStimulus(a, d, 1'b1, 1'b0, dummy);
  endtask

  task automatic busRead(input logic [7:0] a, output logic [7:0] r);
    addr = a;
    #1;
    r = dout;
  endtask

  task automatic setDiv(input logic [15:0] v);
    busWrite(A_DIV_LO, v[7:0]);
    busWrite(A_DIV_HI, v[15:8]);
    divVal = int'(v);
  endtask

  function automatic logic [7:0] expStatus();
    return {2'b00, frameErrModel, overrunModel, (rxModel.size() == 4),
            (rxModel.size() != 0), 1'b1, 1'b0};
  endfunction

  task automatic checkStatus(input string tag);
    logic [7:0] r;
    busRead(A_STATUS, r);
    checkOutput(tag, r, expStatus());
  endtask

  // Drives one frame on rx and records what a correct receiver must do.
  task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      waitCycles(divVal + 1);
    end
    rx = 1'b1;
    if (!stopBit) begin
      frameErrModel = 1'b1;
    end else if (rxModel.size() < 4) begin
      rxModel.push_back(b);
    end else begin
      overrunModel = 1'b1;
    end
  endtask

  task automatic popCheck(input string tag);
    logic [7:0] r;
    logic [7:0] e;
    e = (rxModel.size() != 0) ? rxModel.pop_front() : 8'h00;
    applyStimulus(A_DATA, 8'h00, 1'b0, 1'b1, r);
    checkOutput(tag, r, e);
  endtask

  task automatic waitTxFrames(input int n, input int budget);
    int k;
    k = 0;
    while (txSeen.size() < n && k < budget) begin
      waitCycles(1);
      k++;
    end
    checkOutput("tx_frame_count", txSeen.size(), n);
  endtask

  // Decodes frames on tx by mid-bit sampling at the currently programmed rate.
  initial begin : txMonitor
    int p;
    int startCyc;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (monEnable && tx === 1'b0) begin
        p = divVal + 1;
        startCyc = cycleCnt;
        repeat (p / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (p) @(negedge clk);
          b[i] = tx;
        end
        repeat (p) @(negedge clk);
        if (tx !== 1'b1) begin
          b = ~b;
        end
        txSeen.push_back(b);
        txStart.push_back(startCyc);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errorCount + 1, checkCount + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : mainSeq
    logic [7:0] r;
    logic [7:0] burst[6];
    logic [7:0] pat;
    logic [7:0] e;
    int p;

    reset = 1'b1;
    addr  = 8'h00;
    din   = 8'h00;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rx    = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(1);

    busRead(A_STATUS, r);  checkOutput("rst_status", r, 8'h02);
    busRead(A_DIV_LO, r);  checkOutput("rst_div_lo", r, 8'h63);
    busRead(A_DIV_HI, r);  checkOutput("rst_div_hi", r, 8'h03);
    busRead(A_DATA, r);    checkOutput("rst_data", r, 8'h00);
    checkOutput("rst_tx", tx, 1'b1);
    waitCycles(1);

    setDiv(16'd3);
    busRead(A_DIV_LO, r);  checkOutput("div_lo_rb", r, 8'h03);
    busRead(A_DIV_HI, r);  checkOutput("div_hi_rb", r, 8'h00);
    waitCycles(1);
    monEnable = 1'b1;

    // Single frame 0xA5: latency, bit pattern and busy duration.
    pat = 8'hA5;
    busWrite(A_DATA, pat);
    waitCycles(1);
    checkOutput("tx_edge_n1", tx, 1'b1);
    waitCycles(1);
    checkOutput("tx_edge_n2", tx, 1'b0);
    for (int b = 0; b < 9; b++) begin
      waitCycles(2);
      e = (b == 0) ? 8'h00 : {7'd0, pat[b-1]};
      checkOutput($sformatf("tx_bit%0d", b), tx, e);
      waitCycles(2);
    end
    waitCycles(2);
    checkOutput("tx_stop", tx, 1'b1);
    busRead(A_STATUS, r);
    checkOutput("tx_busy_end", r[6], 1'b1);
    waitCycles(1);
    busRead(A_STATUS, r);
    checkOutput("tx_idle_after", r, 8'h02);
    waitCycles(1);

    // Burst of six writes: five accepted, the sixth lands on a full FIFO.
    txSeen.delete();
    txStart.delete();
    for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) busWrite(A_DATA, burst[i]);
    busRead(A_STATUS, r);
    checkOutput("burst_status_full", r, 8'h41);
    waitTxFrames(5, 5 * 40 + 100);
    for (int i = 0; i < 5 && i < txSeen.size(); i++) begin
      checkOutput($sformatf("burst_byte%0d", i), txSeen[i], burst[i]);
    end
    for (int i = 1; i < 5 && i < txStart.size(); i++) begin
      checkOutput($sformatf("burst_gap%0d", i), txStart[i] - txStart[i-1], 40);
    end
    waitCycles(6);
    busRead(A_STATUS, r);
    checkOutput("burst_done_status", r, 8'h02);
    waitCycles(60);
    checkOutput("burst_no_sixth", txSeen.size(), 5);

    // RX single frame, empty read, then a short glitch.
    sendRxFrame(8'h3C, 1'b1);
    waitCycles(4);
    checkStatus("rx_valid_status");
    popCheck("rx_data_3c");
    checkStatus("rx_after_pop");
    popCheck("rx_empty_read");
    rx = 1'b0;
    waitCycles(2);
    rx = 1'b1;
    waitCycles(50);
    checkStatus("rx_glitch_status");

    // Five frames without reading: fifth overruns.
    for (int i = 0; i < 5; i++) sendRxFrame(8'($urandom), 1'b1);
    waitCycles(4);
    checkStatus("rx_overrun_status");
    busWrite(A_STATUS, 8'h10);
    overrunModel = 1'b0;
    checkStatus("rx_overrun_clear");
    for (int i = 0; i < 4; i++) popCheck($sformatf("rx_keep%0d", i));
    checkStatus("rx_drained");

    // Bad stop bit, then recovery with a good frame.
    sendRxFrame(8'($urandom), 1'b0);
    waitCycles(8);
    checkStatus("rx_frame_err");
    busWrite(A_STATUS, 8'h20);
    frameErrModel = 1'b0;
    checkStatus("rx_frame_err_clear");
    sendRxFrame(8'($urandom), 1'b1);
    waitCycles(4);
    popCheck("rx_after_ferr");

    // Random divisors: RX frames, and a combined read+write of DATA.
    for (int it = 0; it < 3; it++) begin
      setDiv(16'($urandom_range(2, 7)));
      p = divVal + 1;
      waitCycles(2);
      sendRxFrame(8'($urandom), 1'b1);
      sendRxFrame(8'($urandom), 1'b1);
      waitCycles(4);
      checkStatus($sformatf("rnd%0d_status", it));
      popCheck($sformatf("rnd%0d_rx0", it));
      txSeen.delete();
      txStart.delete();
      pat = 8'($urandom);
      e = rxModel.pop_front();
      applyStimulus(A_DATA, pat, 1'b1, 1'b1, r);
      checkOutput($sformatf("rnd%0d_rx1_rdwr", it), r, e);
      waitTxFrames(1, 12 * p + 20);
      if (txSeen.size() > 0) checkOutput($sformatf("rnd%0d_tx", it), txSeen[0], pat);
      waitCycles(p + 3);
      checkStatus($sformatf("rnd%0d_idle", it));
    end

    // Reset in the middle of a transmit frame.
    monEnable = 1'b0;
    for (int i = 0; i < 3; i++) busWrite(A_DATA, 8'($urandom));
    waitCycles(10);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_tx", tx, 1'b1);
    busRead(A_STATUS, r);  checkOutput("midrst_status", r, 8'h02);
    busRead(A_DIV_LO, r);  checkOutput("midrst_div_lo", r, 8'h63);
    @(posedge clk);
    #1;
    reset = 1'b0;
    divVal = 867;
    waitCycles(3);
    checkOutput("postrst_tx", tx, 1'b1);
    busRead(A_STATUS, r);  checkOutput("postrst_status", r, 8'h02);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
